// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared types and constants for the countdown timer.
//   STATE_W : width of the timer state encoding
//   state_t : IDLE (waiting for a load) / RUN (counting down)
package countdown_timer_pkg;

  localparam int unsigned STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_prescaler.sv
// countdown_timer_prescaler: divides enabled RUN cycles by Prescale and
// produces a one-cycle tick on the last cycle of each division period.
// This module is used only when COUNTDOWN_TIMER_PRESCALE_EN is defined.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   run    : timer is in RUN
//   enable : decrement qualifier
//   clear  : restart the division period (load accept, stop, reload)
//   tick   : one-cycle decrement strobe
module countdown_timer_prescaler #(
  parameter int unsigned Prescale = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [PW-1:0] LAST = PW'(Prescale - 1);

  logic [PW-1:0] pre_q;
  logic          active;

  assign active = run && enable;
  assign tick   = active && (pre_q == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else if (clear) begin
      pre_q <= '0;
    end else if (active) begin
      pre_q <= (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end
  end

endmodule : countdown_timer_prescaler

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with valid/ready load, one-cycle
// expiry pulse, optional auto-reload and a wrapping expiry counter.
// Build option: define COUNTDOWN_TIMER_PRESCALE_EN to decrement only once
// every Prescale enabled cycles (otherwise every enabled cycle).
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   load_valid   : load request
//   load_value   : start value, taken when load_valid && load_ready
//   load_ready   : timer idle and not stopped (combinational)
//   enable       : decrement qualifier; count holds when low
//   reload       : at expiry, 1 = restart from latched value, 0 = go idle
//   stop         : synchronous abort, no expiry pulse
//   count        : remaining count
//   busy         : high while in RUN
//   expired      : one-cycle expiry pulse
//   expiry_count : number of expiries, modulo 2^Size
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned Size     = 5,
  parameter int unsigned Prescale = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [Size-1:0] load_value,
  output logic            load_ready,
  input  logic            enable,
  input  logic            reload,
  input  logic            stop,
  output logic [Size-1:0] count,
  output logic            busy,
  output logic            expired,
  output logic [Size-1:0] expiry_count
);

  state_t          state_q, state_d;
  logic [Size-1:0] count_q, count_d;
  logic [Size-1:0] latched_q, latched_d;
  logic [Size-1:0] expiry_q, expiry_d;
  logic            expired_q, expired_d;

  logic accept;
  logic tick;
  logic at_last;

  assign load_ready = (state_q == IDLE) && !stop;
  assign accept     = load_valid && load_ready;
  assign at_last    = (count_q == Size'(1));

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
  logic pre_clear;

  // Reload restarts the period; the prescaler is already wrapping there,
  // so clearing it too keeps the period exactly V*Prescale.
  assign pre_clear = accept || stop ||
                     ((state_q == RUN) && tick && at_last && reload);

  countdown_timer_prescaler #(
    .Prescale (Prescale)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .run    (state_q == RUN),
    .enable (enable),
    .clear  (pre_clear),
    .tick   (tick)
  );
`else
  assign tick = enable;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && (load_value != '0)) state_d = RUN;
      RUN: begin
        if (stop)                           state_d = IDLE;
        else if (tick && at_last && !reload) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; stop takes priority over expiry.
  always_comb begin
    count_d   = count_q;
    latched_d = latched_q;
    expiry_d  = expiry_q;
    expired_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          latched_d = load_value;
          count_d   = load_value;
          if (load_value == '0) begin
            expired_d = 1'b1;
            expiry_d  = expiry_q + Size'(1);
          end
        end
      end
      RUN: begin
        if (stop) begin
          count_d = '0;
        end else if (tick) begin
          if (at_last) begin
            expired_d = 1'b1;
            expiry_d  = expiry_q + Size'(1);
            count_d   = reload ? latched_q : '0;
          end else begin
            count_d = count_q - Size'(1);
          end
        end
      end
      default: count_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      latched_q <= '0;
      expiry_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      latched_q <= latched_d;
      expiry_q  <= expiry_d;
      expired_q <= expired_d;
    end
  end

  assign count        = count_q;
  assign busy         = (state_q == RUN);
  assign expired      = expired_q;
  assign expiry_count = expiry_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer.
// Expected output snapshots are queued as each step is driven and popped
// and compared one time unit after the following clock edge.
module tb_countdown_timer;

  localparam int unsigned SIZE = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            load_valid = 1'b0;
  logic [SIZE-1:0] load_value = '0;
  logic            load_ready;
  logic            enable = 1'b0;
  logic            reload = 1'b0;
  logic            stop = 1'b0;
  logic [SIZE-1:0] count;
  logic            busy;
  logic            expired;
  logic [SIZE-1:0] expiry_count;

  int checks   = 0;
  int failures = 0;
  int ec       = 0;

  typedef struct {
    string           tag;
    logic [SIZE-1:0] cnt;
    logic            bsy;
    logic            exp;
    logic [SIZE-1:0] ecnt;
    logic            lr;
  } exp_t;

  exp_t sb[$];

  countdown_timer #(
    .Size     (SIZE),
    .Prescale (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_value   (load_value),
    .load_ready   (load_ready),
    .enable       (enable),
    .reload       (reload),
    .stop         (stop),
    .count        (count),
    .busy         (busy),
    .expired      (expired),
    .expiry_count (expiry_count)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input int c, input bit b, input bit e,
                      input int k, input bit lr);
    exp_t x;
    x.tag  = tag;
    x.cnt  = SIZE'(c);
    x.bsy  = b;
    x.exp  = e;
    x.ecnt = SIZE'(k);
    x.lr   = lr;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t x;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=0 want=1");
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      assert (count === x.cnt) else begin
        failures++;
        $error("FAIL %s.count got=%0d want=%0d", x.tag, count, x.cnt);
      end
      checks++;
      assert (busy === x.bsy) else begin
        failures++;
        $error("FAIL %s.busy got=%b want=%b", x.tag, busy, x.bsy);
      end
      checks++;
      assert (expired === x.exp) else begin
        failures++;
        $error("FAIL %s.expired got=%b want=%b", x.tag, expired, x.exp);
      end
      checks++;
      assert (expiry_count === x.ecnt) else begin
        failures++;
        $error("FAIL %s.expiry_count got=%0d want=%0d", x.tag, expiry_count, x.ecnt);
      end
      checks++;
      assert (load_ready === x.lr) else begin
        failures++;
        $error("FAIL %s.load_ready got=%b want=%b", x.tag, load_ready, x.lr);
      end
    end
  endtask

  // Expect the given outputs one time unit after the next rising edge.
  task automatic cyc(input string tag, input int c, input bit b, input bit e,
                     input int k, input bit lr);
    push(tag, c, b, e, k, lr);
    @(posedge clock);
    #1;
    check_now();
  endtask

  initial begin
    // Reset state
    #2;
    push("reset_init", 0, 0, 0, 0, 1);
    check_now();
    @(posedge clock);
    #1;
    reset = 1'b1;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    // Prescale 4, load 2: expiry after 8 enabled cycles; loads refused in RUN
    load_valid = 1'b1; load_value = 5'd2; enable = 1'b1; reload = 1'b0;
    cyc("ps_load", 2, 1, 0, 0, 0);
    load_value = 5'd9;
    for (int unsigned i = 1; i <= 3; i++) cyc("ps_hold2", 2, 1, 0, 0, 0);
    load_valid = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) cyc("ps_hold1", 1, 1, 0, 0, 0);
    cyc("ps_expire", 0, 0, 1, 1, 1);
    cyc("ps_idle", 0, 0, 0, 1, 1);
    ec = 1;
`else
    // One-shot load 3
    load_valid = 1'b1; load_value = 5'd3; enable = 1'b1; reload = 1'b0;
    cyc("os_load", 3, 1, 0, 0, 0);
    load_valid = 1'b0;
    cyc("os_2", 2, 1, 0, 0, 0);
    cyc("os_1", 1, 1, 0, 0, 0);
    cyc("os_expire", 0, 0, 1, 1, 1);
    cyc("os_after", 0, 0, 0, 1, 1);

    // Zero load
    load_valid = 1'b1; load_value = 5'd0;
    cyc("zero_pulse", 0, 0, 1, 2, 1);
    load_valid = 1'b0;
    cyc("zero_after", 0, 0, 0, 2, 1);

    // Hold: enable low for 3 cycles after the first decrement
    load_valid = 1'b1; load_value = 5'd4;
    cyc("hold_load", 4, 1, 0, 2, 0);
    load_valid = 1'b0;
    cyc("hold_3", 3, 1, 0, 2, 0);
    enable = 1'b0;
    for (int unsigned i = 0; i < 3; i++) cyc("hold_keep", 3, 1, 0, 2, 0);
    enable = 1'b1;
    cyc("hold_2", 2, 1, 0, 2, 0);
    cyc("hold_1", 1, 1, 0, 2, 0);
    cyc("hold_expire", 0, 0, 1, 3, 1);
    cyc("hold_after", 0, 0, 0, 3, 1);

    // Stop on the count==1 cycle: no pulse
    load_valid = 1'b1; load_value = 5'd10;
    cyc("stop_load", 10, 1, 0, 3, 0);
    load_valid = 1'b0;
    for (int i = 9; i >= 1; i--) cyc("stop_dec", i, 1, 0, 3, 0);
    stop = 1'b1;
    cyc("stop_hit", 0, 0, 0, 3, 0);
    // Stop in IDLE refuses the load
    load_valid = 1'b1; load_value = 5'd5;
    cyc("stop_idle", 0, 0, 0, 3, 0);
    stop = 1'b0; load_valid = 1'b0;
    cyc("stop_release", 0, 0, 0, 3, 1);

    // Periodic load 2 with expiry counter wrap
    ec = 3;
    load_valid = 1'b1; load_value = 5'd2; reload = 1'b1;
    cyc("per_load", 2, 1, 0, ec, 0);
    load_valid = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      cyc("per_1", 1, 1, 0, ec, 0);
      ec = (ec + 1) % 32;
      cyc("per_expire", 2, 1, 1, ec, 0);
    end
    stop = 1'b1;
    cyc("per_stop", 0, 0, 0, ec, 0);
    stop = 1'b0;

    // V=1 with reload: one pulse per cycle, then one-shot exit
    load_valid = 1'b1; load_value = 5'd1;
    cyc("v1_load", 1, 1, 0, ec, 0);
    load_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      ec = (ec + 1) % 32;
      cyc("v1_train", 1, 1, 1, ec, 0);
    end
    reload = 1'b0;
    ec = (ec + 1) % 32;
    cyc("v1_last", 0, 0, 1, ec, 1);
    cyc("v1_after", 0, 0, 0, ec, 1);
`endif

    // Asynchronous reset mid-run with count=7 (hold via enable=0)
    enable = 1'b0;
    load_valid = 1'b1; load_value = 5'd7;
    cyc("rst_load", 7, 1, 0, ec, 0);
    load_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    push("rst_async", 0, 0, 0, 0, 1);
    check_now();
    #3;
    reset = 1'b1;
    cyc("rst_after", 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_countdown_timer
